// File: rtl/ofdm_subcarrier_map_if.sv
// Stream bundle between the pilot-insertion stage, the subcarrier mapper
// and the IFFT.
//
// Handshake: the input side has no backpressure. din_* is taken on every
// edge where din_vld is high. The output side advances only on edges where
// dout_rdy is high. dout_vld marks the cycles that carry a real bin, and
// dout_* holds its value while dout_rdy is low.
interface ofdm_subcarrier_map_if #(
    parameter int DW = 8
);
    logic [DW-1:0] din_re;
    logic [DW-1:0] din_im;
    logic          din_vld;
    logic          dout_rdy;
    logic [DW-1:0] dout_re;
    logic [DW-1:0] dout_im;
    logic          dout_vld;
    logic          dout_sop;
    logic          dout_eop;
    logic          ovf;

    // Upstream/downstream environment side.
    modport master (
        output din_re, din_im, din_vld, dout_rdy,
        input  dout_re, dout_im, dout_vld, dout_sop, dout_eop, ovf
    );

    // Mapper side.
    modport slave (
        input  din_re, din_im, din_vld, dout_rdy,
        output dout_re, dout_im, dout_vld, dout_sop, dout_eop, ovf
    );
endinterface

// File: rtl/ofdm_subcarrier_map.sv
// OFDM subcarrier mapper.
// The block takes 52 occupied subcarriers per symbol, in order -26..-1 and
// then +1..+26. It writes them into one half of a ping-pong buffer at their
// IFFT bin positions. It then streams 64 bins per symbol, with the DC bin
// and the guard bins forced to zero.
module ofdm_subcarrier_map #(
    parameter int DW     = 8,
    parameter int N_USED = 52
) (
    input  logic                   sys_clk,
    input  logic                   rst_n,
    input  logic                   tx_clr,
    ofdm_subcarrier_map_if.slave   bus,
    output logic                   dbg_state
);

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [5:0]    wr_cnt_q, wr_cnt_d;
    logic [5:0]    rd_cnt_q, rd_cnt_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [1:0]    full_q, full_d;
    logic          ovf_q, ovf_d;
    logic [DW-1:0] dout_re_q, dout_re_d;
    logic [DW-1:0] dout_im_q, dout_im_d;
    logic          dout_vld_q, dout_vld_d;
    logic          dout_sop_q, dout_sop_d;
    logic          dout_eop_q, dout_eop_d;

    // Two banks of 64 bins, addressed as {bank, bin}; {re, im} per word.
    logic [2*DW-1:0] mem_q [0:127];

    logic          wr_acc;
    logic [5:0]    wr_bin;
    logic [1:0]    wr_set;
    logic [1:0]    rd_clr;
    logic          rd_en;
    logic          rd_null;
    logic [2*DW-1:0] rd_word;

    // A sample is dropped whenever the bank it would land in still waits to be read.
    assign wr_acc  = bus.din_vld && !full_q[wr_bank_q];
    // Negative subcarriers go to the top bins; positive ones go just above DC.
    assign wr_bin  = (wr_cnt_q < 6'd26) ? (wr_cnt_q + 6'd38) : (wr_cnt_q - 6'd25);
    // DC (bin 0) and guard bins 27..37 are never occupied.
    assign rd_null = (rd_cnt_q == 6'd0) || ((rd_cnt_q >= 6'd27) && (rd_cnt_q <= 6'd37));
    assign rd_word = mem_q[{rd_bank_q, rd_cnt_q}];
    assign full_d  = (full_q | wr_set) & ~rd_clr;

    // Write side: count accepted samples, hand a finished bank to the reader, flag drops.
    always_comb begin
        wr_cnt_d  = wr_cnt_q;
        wr_bank_d = wr_bank_q;
        wr_set    = 2'b00;
        ovf_d     = ovf_q;
        if (wr_acc) begin
            if (wr_cnt_q == 6'(N_USED - 1)) begin
                wr_cnt_d  = 6'd0;
                wr_bank_d = ~wr_bank_q;
                wr_set    = wr_bank_q ? 2'b10 : 2'b01;
            end else begin
                wr_cnt_d = wr_cnt_q + 6'd1;
            end
        end
        if (bus.din_vld && full_q[wr_bank_q]) begin
            ovf_d = 1'b1;
        end
    end

    // Read FSM: wait for a full bank, then walk bins 0..63 as dout_rdy allows.
    always_comb begin
        state_d   = state_q;
        rd_cnt_d  = rd_cnt_q;
        rd_bank_d = rd_bank_q;
        rd_clr    = 2'b00;
        rd_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d  = READ;
                    rd_cnt_d = 6'd0;
                end
            end
            READ: begin
                if (bus.dout_rdy) begin
                    rd_en    = 1'b1;
                    rd_cnt_d = rd_cnt_q + 6'd1;
                    if (rd_cnt_q == 6'd63) begin
                        rd_clr    = rd_bank_q ? 2'b10 : 2'b01;
                        rd_bank_d = ~rd_bank_q;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output register: a new bin on each read cycle, held data otherwise.
    always_comb begin
        dout_re_d  = dout_re_q;
        dout_im_d  = dout_im_q;
        dout_vld_d = rd_en;
        dout_sop_d = rd_en && (rd_cnt_q == 6'd0);
        dout_eop_d = rd_en && (rd_cnt_q == 6'd63);
        if (rd_en) begin
            dout_re_d = rd_null ? '0 : rd_word[2*DW-1:DW];
            dout_im_d = rd_null ? '0 : rd_word[DW-1:0];
        end
    end

    // Control and output state. A frame-start clear has the same effect as reset.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            full_q     <= 2'b00;
            ovf_q      <= 1'b0;
            dout_re_q  <= '0;
            dout_im_q  <= '0;
            dout_vld_q <= 1'b0;
            dout_sop_q <= 1'b0;
            dout_eop_q <= 1'b0;
        end else if (tx_clr) begin
            state_q    <= IDLE;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            full_q     <= 2'b00;
            ovf_q      <= 1'b0;
            dout_re_q  <= '0;
            dout_im_q  <= '0;
            dout_vld_q <= 1'b0;
            dout_sop_q <= 1'b0;
            dout_eop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            full_q     <= full_d;
            ovf_q      <= ovf_d;
            dout_re_q  <= dout_re_d;
            dout_im_q  <= dout_im_d;
            dout_vld_q <= dout_vld_d;
            dout_sop_q <= dout_sop_d;
            dout_eop_q <= dout_eop_d;
        end
    end

    // Buffer write; contents are deliberately left uninitialised by reset.
    always_ff @(posedge sys_clk) begin
        if (wr_acc && !tx_clr) begin
            mem_q[{wr_bank_q, wr_bin}] <= {bus.din_re, bus.din_im};
        end
    end

    assign bus.dout_re  = dout_re_q;
    assign bus.dout_im  = dout_im_q;
    assign bus.dout_vld = dout_vld_q;
    assign bus.dout_sop = dout_sop_q;
    assign bus.dout_eop = dout_eop_q;
    assign bus.ovf      = ovf_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_ofdm_subcarrier_map.sv
// Directed bench for the OFDM subcarrier mapper.
module tb_ofdm_subcarrier_map;
    localparam int DW = 8;

    typedef struct {
        int           cyc;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic         sop;
        logic         eop;
    } cap_t;

    logic sys_clk = 1'b0;
    logic rst_n;
    logic tx_clr;
    logic dbg_state;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   last_cyc;
    int   e0;
    cap_t cap_q[$];
    cap_t mon_c;
    logic [2*DW+1:0] exp_q[$];

    ofdm_subcarrier_map_if #(.DW(DW)) bus ();

    ofdm_subcarrier_map #(.DW(DW), .N_USED(52)) dut (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .tx_clr    (tx_clr),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    // clock / cycle counter
    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // output monitor: record every valid output away from the active edge
    always @(negedge sys_clk) begin
        if (bus.dout_vld === 1'b1) begin
            mon_c.cyc = cyc;
            mon_c.re  = bus.dout_re;
            mon_c.im  = bus.dout_im;
            mon_c.sop = bus.dout_sop;
            mon_c.eop = bus.dout_eop;
            cap_q.push_back(mon_c);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] pay_re(input int s, input int k);
        return DW'(k + 1 + 64 * s);
    endfunction

    function automatic logic [DW-1:0] pay_im(input int s, input int k);
        return DW'(-(k + 1 + 64 * s));
    endfunction

    // expected {re, im} for IFFT bin b of payload s
    function automatic logic [2*DW-1:0] exp_bin(input int s, input int b);
        int k;
        if (b == 0 || (b >= 27 && b <= 37)) return '0;
        k = (b <= 26) ? (b + 25) : (b - 38);
        return {pay_re(s, k), pay_im(s, k)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // drive n samples of payload s on consecutive cycles, then one idle cycle
    task automatic send_sym(input int s, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge sys_clk);
            bus.din_vld = 1'b1;
            bus.din_re  = pay_re(s, k);
            bus.din_im  = pay_im(s, k);
        end
        @(negedge sys_clk);
        bus.din_vld = 1'b0;
        last_cyc    = cyc;
    endtask

    task automatic wait_caps(input int n, input int budget);
        int i;
        i = 0;
        while (cap_q.size() < n && i < budget) begin
            @(negedge sys_clk);
            i++;
        end
        chk("cap_count", cap_q.size(), n);
    endtask

    // compare n captured bins from index base against payload s; an optional
    // stall of stall_len cycles is expected before bin stall_at
    task automatic check_burst(input int s, input int base, input int n,
                               input int stall_at, input int stall_len);
        logic [2*DW+1:0] e;
        cap_t c;
        if (cap_q.size() < base + n) begin
            chk("burst_len", cap_q.size(), base + n);
            return;
        end
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({(i == 0), (i == 63), exp_bin(s, i)});
        end
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            c = cap_q[base + i];
            chk($sformatf("bin%0d_s%0d", i, s), {14'd0, c.sop, c.eop, c.re, c.im}, {14'd0, e});
            chk($sformatf("time%0d_s%0d", i, s), c.cyc - cap_q[base].cyc,
                i + ((i >= stall_at) ? stall_len : 0));
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        tx_clr       = 1'b0;
        bus.din_vld  = 1'b0;
        bus.din_re   = '0;
        bus.din_im   = '0;
        bus.dout_rdy = 1'b1;

        // reset state
        #12;
        chk("rst_vld", bus.dout_vld, 0);
        chk("rst_sop", bus.dout_sop, 0);
        chk("rst_eop", bus.dout_eop, 0);
        chk("rst_re",  bus.dout_re, 0);
        chk("rst_im",  bus.dout_im, 0);
        chk("rst_ovf", bus.ovf, 0);
        chk("rst_state", dbg_state, 0);
        @(negedge sys_clk);
        rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        // single symbol
        send_sym(0, 52);
        wait_caps(64, 200);
        if (cap_q.size() > 0) chk("latency1", cap_q[0].cyc - last_cyc, 2);
        check_burst(0, 0, 64, 64, 0);
        repeat (4) @(negedge sys_clk);
        cap_q.delete();

        // three back-to-back symbols at 52-of-80 duty
        for (int s = 1; s <= 3; s++) begin
            send_sym(s, 52);
            repeat (27) @(negedge sys_clk);
        end
        wait_caps(192, 400);
        for (int b = 0; b < 3; b++) check_burst(b + 1, 64 * b, 64, 64, 0);
        for (int b = 1; b < 3; b++) begin
            if (cap_q.size() >= 64 * b + 1)
                chk("burst_gap", (cap_q[64 * b].cyc - cap_q[64 * b - 1].cyc) >= 2, 1);
        end
        chk("b2b_ovf", bus.ovf, 0);
        repeat (4) @(negedge sys_clk);
        cap_q.delete();

        // backpressure: dout_rdy low for 5 read cycles at bin 10
        send_sym(2, 52);
        e0 = last_cyc;
        repeat (11) @(negedge sys_clk);
        bus.dout_rdy = 1'b0;
        @(negedge sys_clk);
        chk("stall_vld", bus.dout_vld, 0);
        chk("stall_hold_re", bus.dout_re, pay_re(2, 34));
        chk("stall_hold_im", bus.dout_im, pay_im(2, 34));
        repeat (4) @(negedge sys_clk);
        bus.dout_rdy = 1'b1;
        wait_caps(64, 200);
        if (cap_q.size() > 0) chk("latency_bp", cap_q[0].cyc - e0, 2);
        check_burst(2, 0, 64, 10, 5);
        repeat (4) @(negedge sys_clk);
        cap_q.delete();

        // overflow: three symbols with the reader stalled
        bus.dout_rdy = 1'b0;
        send_sym(1, 52);
        send_sym(2, 52);
        send_sym(3, 52);
        chk("ovf_set", bus.ovf, 1);
        chk("ovf_no_out", cap_q.size(), 0);
        chk("ovf_state", dbg_state, 1);
        bus.dout_rdy = 1'b1;
        repeat (300) @(negedge sys_clk);
        chk("ovf_two_syms", cap_q.size(), 128);
        check_burst(1, 0, 64, 64, 0);
        check_burst(2, 64, 64, 64, 0);
        chk("ovf_sticky", bus.ovf, 1);
        cap_q.delete();

        // mid-symbol clear: at output bin 30, 20 inputs into the next symbol
        send_sym(2, 52);
        e0 = last_cyc;
        send_sym(3, 20);
        repeat (e0 + 31 - cyc) @(negedge sys_clk);
        tx_clr = 1'b1;
        @(negedge sys_clk);
        tx_clr = 1'b0;
        chk("clr_vld", bus.dout_vld, 0);
        chk("clr_ovf", bus.ovf, 0);
        chk("clr_state", dbg_state, 0);
        repeat (3) @(negedge sys_clk);
        chk("clr_partial", cap_q.size(), 30);
        check_burst(2, 0, 30, 64, 0);
        cap_q.delete();
        send_sym(1, 52);
        wait_caps(64, 200);
        if (cap_q.size() > 0) chk("latency_clr", cap_q[0].cyc - last_cyc, 2);
        check_burst(1, 0, 64, 64, 0);
        repeat (4) @(negedge sys_clk);
        cap_q.delete();

        // asynchronous reset during READ
        send_sym(0, 52);
        repeat (10) @(negedge sys_clk);
        chk("ar_pre_vld", bus.dout_vld, 1);
        chk("ar_pre_re", bus.dout_re, pay_re(0, 33));
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_vld", bus.dout_vld, 0);
        chk("ar_sop", bus.dout_sop, 0);
        chk("ar_eop", bus.dout_eop, 0);
        chk("ar_re",  bus.dout_re, 0);
        chk("ar_im",  bus.dout_im, 0);
        chk("ar_ovf", bus.ovf, 0);
        chk("ar_state", dbg_state, 0);
        @(negedge sys_clk);
        rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        chk("ar_post_state", dbg_state, 0);
        chk("ar_post_vld", bus.dout_vld, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
